uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with a small first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to receive and check one parity bit per frame.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_pin_in,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic                 s1, s2, s3;
  logic                 fall, tick, last_bit;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 push, ferr_c, perr_c;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic                 full, pop, wr_en;

  // s3 is the previous synchronized sample, used only for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx_pin_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall     = s3 & ~s2;
  assign last_bit = bit_idx == BW'(DATA_BITS - 1);

  always_comb begin
    tick = 1'b0;
    unique case (state)
      IDLE, WAIT_HIGH: tick = 1'b0;
      START:           tick = cnt == CW'(HALF - 1);
      default:         tick = cnt == CW'(DIV - 1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (fall) state_n = START;
      START:     if (tick) state_n = s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (tick && last_bit) state_n = PARITY;
      PARITY:    if (tick) state_n = STOP;
`else
      DATA:      if (tick && last_bit) state_n = STOP;
`endif
      STOP:      if (tick) state_n = s2 ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (s2) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    push   = (state == STOP) && tick && s2 && !par_bad;
    ferr_c = (state == STOP) && tick && !s2;
`ifdef UART_RX_PARITY_EN
    perr_c = (state == PARITY) && tick &&
             ((^shreg ^ s2) != 1'(PARITY_ODD));
`else
    perr_c = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE || state == WAIT_HIGH || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
      if (state == DATA && tick) shreg <= {s2, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // a bad parity bit poisons the word until the next start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 par_bad <= 1'b0;
    else if (state == START) par_bad <= 1'b0;
    else if (perr_c)         par_bad <= 1'b1;
  end
`else
  assign par_bad = 1'b0;
`endif

  assign full     = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign rx_valid = fifo_count != '0;
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      frame_err  <= ferr_c;
      parity_err <= perr_c;
      overrun    <= push & full & ~pop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus corner sequences.
// Bit period shrunk to 16 clocks to keep run length short.
module tb_uart_rx_fifo;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err, parity_err, overrun;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  int ferr_n = 0;
  int perr_n = 0;
  int ovr_n = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_cnt;
    int         exp_ferr;
  } vec_t;

  vec_t tv [7];

  uart_rx_fifo #(
    .CLK_FREQ  (16_000_000),
    .BAUD_RATE (1_000_000),
    .DATA_BITS (8),
    .FIFO_DEPTH(4),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pin_in (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1)  ferr_n++;
    if (parity_err === 1'b1) perr_n++;
    if (overrun === 1'b1)    ovr_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input logic par);
    rx_line = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      cyc(DIV);
    end
`ifdef UART_RX_PARITY_EN
    rx_line = par;
    cyc(DIV);
`else
    if (par === 1'bx) rx_line = 1'b0;
`endif
    rx_line = stop;
    cyc(DIV);
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int f0, o0, p0;
    tv[0] = '{8'h30, 1'b1, 1'b1, 8'h30, 1, 0};
    tv[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1, 0};
    tv[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1, 0};
    tv[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};
    tv[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1, 0};
    tv[5] = '{8'h81, 1'b0, 1'b0, 8'h00, 0, 1};
    tv[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1, 0};

    cyc(3);
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_data", {24'd0, rx_data}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_flags", {29'd0, frame_err, parity_err, overrun}, 0);
    rst = 1'b0;
    cyc(4);

    for (int i = 0; i < 7; i++) begin
      f0 = ferr_n;
      send(tv[i].d, tv[i].stop, ^tv[i].d);
      rx_line = 1'b1;
      cyc(2 * DIV);
      chk($sformatf("vec%0d_valid", i), {31'd0, rx_valid},
          {31'd0, tv[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {24'd0, rx_data},
          {24'd0, tv[i].exp_data});
      chk($sformatf("vec%0d_count", i), {29'd0, fifo_count}, tv[i].exp_cnt);
      chk($sformatf("vec%0d_ferr", i), ferr_n - f0, tv[i].exp_ferr);
      if (tv[i].exp_valid) pop();
      cyc(1);
      chk($sformatf("vec%0d_popped", i), {29'd0, fifo_count}, 0);
    end

    // short low glitch on an idle line
    f0 = ferr_n;
    rx_line = 1'b0;
    cyc(3);
    rx_line = 1'b1;
    cyc(3 * DIV);
    chk("glitch_count", {29'd0, fifo_count}, 0);
    chk("glitch_ferr", ferr_n - f0, 0);
    send(8'h5A, 1'b1, ^8'h5A);
    rx_line = 1'b1;
    cyc(DIV);
    chk("glitch_next", {24'd0, rx_data}, 32'h5A);
    pop();

    // break: stop bit low, then line held low for many bit times
    f0 = ferr_n;
    send(8'h55, 1'b0, ^8'h55);
    cyc(30 * DIV);
    chk("break_ferr_low", ferr_n - f0, 1);
    rx_line = 1'b1;
    cyc(3 * DIV);
    chk("break_ferr", ferr_n - f0, 1);
    chk("break_count", {29'd0, fifo_count}, 0);

    // fill FIFO, fifth frame overruns
    o0 = ovr_n;
    for (int k = 1; k <= 4; k++) begin
      send(8'(k), 1'b1, ^8'(k));
      rx_line = 1'b1;
      cyc(DIV);
    end
    chk("fill_ovr", ovr_n - o0, 0);
    chk("fill_count", {29'd0, fifo_count}, 4);
    send(8'h05, 1'b1, ^8'h05);
    rx_line = 1'b1;
    cyc(DIV);
    chk("ovr_pulse", ovr_n - o0, 1);
    chk("ovr_count", {29'd0, fifo_count}, 4);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovr_pop%0d", k), {24'd0, rx_data}, k);
      pop();
    end
    chk("ovr_empty", {31'd0, rx_valid}, 0);

    // ready while empty must not underflow
    rx_ready = 1'b1;
    cyc(3);
    rx_ready = 1'b0;
    chk("empty_rdy_count", {29'd0, fifo_count}, 0);
    send(8'h3C, 1'b1, ^8'h3C);
    rx_line = 1'b1;
    cyc(DIV);
    chk("empty_rdy_next", {29'd0, fifo_count}, 1);
    chk("empty_rdy_data", {24'd0, rx_data}, 32'h3C);
    pop();

`ifdef UART_RX_PARITY_EN
    p0 = perr_n;
    f0 = ferr_n;
    send(8'h31, 1'b1, 1'b0);
    rx_line = 1'b1;
    cyc(2 * DIV);
    chk("par_bad_perr", perr_n - p0, 1);
    chk("par_bad_count", {29'd0, fifo_count}, 0);
    chk("par_bad_ferr", ferr_n - f0, 0);
    send(8'h31, 1'b1, 1'b1);
    rx_line = 1'b1;
    cyc(2 * DIV);
    chk("par_ok_perr", perr_n - p0, 1);
    chk("par_ok_data", {24'd0, rx_data}, 32'h31);
    pop();
`else
    p0 = 0;
    chk("no_parity_err", perr_n, p0);
`endif

    // reset in the middle of data bit 4
    send(8'h12, 1'b1, ^8'h12);
    rx_line = 1'b1;
    cyc(DIV);
    chk("pre_rst_valid", {31'd0, rx_valid}, 1);
    f0 = ferr_n;
    rx_line = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 4; i++) begin
      rx_line = 8'hA5 >> i;
      cyc(DIV);
    end
    rx_line = 1'b0;
    cyc(DIV / 2);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_valid", {31'd0, rx_valid}, 0);
    chk("mid_rst_data", {24'd0, rx_data}, 0);
    chk("mid_rst_count", {29'd0, fifo_count}, 0);
    rx_line = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2 * DIV);
    chk("post_rst_idle", {29'd0, fifo_count}, 0);
    send(8'hA5, 1'b1, ^8'hA5);
    rx_line = 1'b1;
    cyc(2 * DIV);
    chk("post_rst_data", {24'd0, rx_data}, 32'hA5);
    chk("post_rst_count", {29'd0, fifo_count}, 1);
    chk("post_rst_ferr", ferr_n - f0, 0);
    pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
